// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types, constants and LFSR step for the rng share controller
package rng_pkg;

    localparam int          LFSR_W       = 16;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WARMUP,
        ST_RUN
    } rng_state_t;

    // One LFSR advance; the only form in which the generator is stepped.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[14] ^ q[15], q[13:2], q[1] ^ q[15], q[0], q[15]};
    endfunction

endpackage

// File: rtl/rng_share_ctrl_if.sv
// rtl/rng_share_ctrl_if.sv - requester-side bundle: req level in, grant pulse and random word out
//   req_in    : per-requester level request
//   grant_out : one-hot grant pulse
//   rand_out  : random word, valid with grant_out
interface rng_share_ctrl_if #(
    parameter int N_REQ = 4
);
    import rng_pkg::*;

    logic [N_REQ-1:0]  req_in;
    logic [N_REQ-1:0]  grant_out;
    logic [LFSR_W-1:0] rand_out;

    modport master (output req_in, input grant_out, input rand_out);
    modport slave  (input req_in, output grant_out, output rand_out);

endinterface

// File: rtl/rng_share_ctrl_rr_pick.sv
// rtl/rng_share_ctrl_rr_pick.sv - combinational round-robin picker
//   req   : candidate vector
//   ptr   : highest-priority index
//   valid : any candidate present
//   idx   : first candidate at or after ptr, wrapping modulo N
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the farthest offset down so the nearest one to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/rng_share_ctrl.sv
// rtl/rng_share_ctrl.sv - one LFSR noise source shared round-robin between N_REQ requesters
//   clk_in         : system clock
//   rst_in         : asynchronous active-high reset
//   seed_in        : seed, taken in LOAD
//   reseed_in      : pulse, reload seed and re-warm
//   bus            : req_in / grant_out / rand_out bundle
//   busy_out       : high during LOAD and WARMUP
//   draw_count_out : grants since last seed load
module rng_share_ctrl
    import rng_pkg::*;
#(
    parameter int          N_REQ    = 4,
    parameter int          WARMUP   = 16,
    parameter logic [15:0] ZERO_SUB = DEFAULT_SEED
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [LFSR_W-1:0]  seed_in,
    input  logic               reseed_in,
    rng_share_ctrl_if.slave    bus,
    output logic               busy_out,
    output logic [15:0]        draw_count_out
);

    localparam int IW = $clog2(N_REQ);

    rng_state_t        state;
    logic [LFSR_W-1:0] lfsr;
    logic [IW-1:0]     rr_ptr;
    logic [15:0]       warm_cnt;
    logic [N_REQ-1:0]  grant_q;
    logic [LFSR_W-1:0] rand_q;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;

    assign bus.grant_out = grant_q;
    assign bus.rand_out  = rand_q;

    // Last cycle's grantee is masked so a requester still holding req
    // during its one-cycle drop lag is not served twice.
    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (bus.req_in & ~grant_q),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= ST_LOAD;
            lfsr           <= ZERO_SUB;
            rr_ptr         <= '0;
            warm_cnt       <= '0;
            grant_q        <= '0;
            rand_q         <= '0;
            busy_out       <= 1'b1;
            draw_count_out <= '0;
        end else if (reseed_in) begin
            state    <= ST_LOAD;
            grant_q  <= '0;
            busy_out <= 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    lfsr           <= (seed_in == '0) ? ZERO_SUB : seed_in;
                    draw_count_out <= '0;
                    warm_cnt       <= '0;
                    grant_q        <= '0;
                    if (WARMUP > 0) begin
                        state <= ST_WARMUP;
                    end else begin
                        state    <= ST_RUN;
                        busy_out <= 1'b0;
                    end
                end
                ST_WARMUP: begin
                    lfsr     <= lfsr_step(lfsr);
                    warm_cnt <= warm_cnt + 16'd1;
                    if (warm_cnt == 16'(WARMUP - 1)) begin
                        state    <= ST_RUN;
                        busy_out <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (pick_valid) begin
                        grant_q        <= N_REQ'(1) << pick_idx;
                        rand_q         <= lfsr;
                        lfsr           <= lfsr_step(lfsr);
                        rr_ptr         <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        draw_count_out <= draw_count_out + 16'd1;
                    end else begin
                        grant_q <= '0;
                    end
                end
                default: begin
                    state    <= ST_LOAD;
                    grant_q  <= '0;
                    busy_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
